// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM burst read engine:
//   - SDRAM command encodings {CS_N, RAS_N, CAS_N, WE_N}
//   - read-engine FSM state enum
//   - DQM pin levels
//   - width helpers for the cycle counter and capture slot index
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package sdram_pkg;

  // Command encoding, {CS_N, RAS_N, CAS_N, WE_N}.
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_READ = 4'b0101;
  localparam logic [3:0] CMD_PRE  = 4'b0010;

  // {UDQM, LDQM}. DQM_ON masks both byte lanes; DQM_OFF lets data through.
  localparam logic [1:0] DQM_ON  = 2'b11;
  localparam logic [1:0] DQM_OFF = 2'b00;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ACT,
    ST_RCD,
    ST_RD,
    ST_CL,
    ST_BURST,
    ST_PRE,
    ST_RP,
    ST_DONE
  } rd_state_e;

  // The single down-counter must hold the largest reload value, which is
  // bounded by max(8, T_RCD, T_RP).
  function automatic int cnt_width(input int t_rcd, input int t_rp);
    int m;
    m = 8;
    if (t_rcd > m) m = t_rcd;
    if (t_rp > m) m = t_rp;
    return $clog2(m + 1);
  endfunction

  // Index width for a burst of bl words; a 1-word burst still needs a 1-bit port.
  function automatic int slot_width(input int bl);
    return (bl > 1) ? $clog2(bl) : 1;
  endfunction

endpackage

// File: rtl/sdram_burst_capture.sv
// -----------------------------------------------------------------------------
// sdram_burst_capture
// Registers one SDRAM data word per strobe into a fixed slot of a wide burst
// word. Slot 0 occupies the MSBs. Slots are written in place, so untouched
// slots keep their previous contents until overwritten.
//
// Ports:
//   iclk     in   system clock
//   ireset   in   synchronous active-high reset, clears odata
//   iwr_en   in   write strobe: capture idq this cycle
//   islot    in   slot index (0 = first word of the burst)
//   idq      in   SDRAM read data
//   odata    out  assembled burst word, DQ_W*BURST_LEN bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sdram_burst_capture
  import sdram_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int BURST_LEN = 8
) (
  input  logic                            iclk,
  input  logic                            ireset,
  input  logic                            iwr_en,
  input  logic [slot_width(BURST_LEN)-1:0] islot,
  input  logic [DQ_W-1:0]                 idq,
  output logic [DQ_W*BURST_LEN-1:0]       odata
);

  logic [DQ_W*BURST_LEN-1:0] data_d;
  logic [DQ_W*BURST_LEN-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (iwr_en) begin
      data_d[(BURST_LEN - 1 - int'(islot))*DQ_W +: DQ_W] = idq;
    end
  end

  // NOTE: the burst word is built from flops, not a RAM, so it can and must
  // be cleared on reset; an aborted burst must never leave partial data.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign odata = data_q;

endmodule

// File: rtl/sdram_burst_read.sv
// -----------------------------------------------------------------------------
// sdram_burst_read
// Single-burst SDRAM read engine. On a request it issues ACTIVE, READ and
// PRECHARGE, captures BURST_LEN words into odata (word 0 in the MSBs) and
// pulses ofin for one cycle.
//
// Build option:
//   SDRAM_RD_AUTOPRECHARGE_EN  defined   -> READ carries A10=1 (auto-precharge)
//                                           and the PRE slot issues a NOP.
//                              undefined -> READ carries A10=0 and the PRE
//                                           slot issues PRECHARGE to ibank.
//   ofin latency is the same in both builds.
//
// Ports:
//   iclk, ireset          clock, synchronous active-high reset
//   ireq                  read request, sampled only in IDLE
//   ienb                  pin grant; all DRAM_* outputs are Z while low
//   irow/icolumn/ibank    target address, held stable while obusy
//   obusy                 high from ACT through DONE
//   ofin                  one-cycle completion pulse
//   odata                 captured burst, DQ_W*BURST_LEN bits
//   oread_enable          high from the READ cycle through the last capture
//   DRAM_*                SDRAM pins (DRAM_DQ is the read-data input)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sdram_burst_read
  import sdram_pkg::*;
#(
  parameter int DQ_W      = 16,
  parameter int BURST_LEN = 8,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BANK_W    = 2,
  parameter int CAS_LAT   = 2,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2
) (
  input  logic                      iclk,
  input  logic                      ireset,
  input  logic                      ireq,
  input  logic                      ienb,
  input  logic [ROW_W-1:0]          irow,
  input  logic [COL_W-1:0]          icolumn,
  input  logic [BANK_W-1:0]         ibank,
  output logic                      obusy,
  output logic                      ofin,
  output logic [DQ_W*BURST_LEN-1:0] odata,
  output logic                      oread_enable,
  output wire                       DRAM_CLK,
  output wire                       DRAM_CKE,
  output wire  [ROW_W-1:0]          DRAM_ADDR,
  output wire  [BANK_W-1:0]         DRAM_BA,
  output wire                       DRAM_CS_N,
  output wire                       DRAM_RAS_N,
  output wire                       DRAM_CAS_N,
  output wire                       DRAM_WE_N,
  output wire                       DRAM_UDQM,
  output wire                       DRAM_LDQM,
  input  logic [DQ_W-1:0]           DRAM_DQ
);

  localparam int CNT_W  = cnt_width(T_RCD, T_RP);
  localparam int SLOT_W = slot_width(BURST_LEN);

`ifdef SDRAM_RD_AUTOPRECHARGE_EN
  localparam logic AUTO_PRE = 1'b1;
`else
  localparam logic AUTO_PRE = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (!(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8)) begin : g_bad_burst_len
    $error("sdram_burst_read: BURST_LEN must be 1, 2, 4 or 8");
  end
  if (!(CAS_LAT == 2 || CAS_LAT == 3)) begin : g_bad_cas_lat
    $error("sdram_burst_read: CAS_LAT must be 2 or 3");
  end
  if (T_RCD < 1 || T_RP < 1) begin : g_bad_timing
    $error("sdram_burst_read: T_RCD and T_RP must be at least 1");
  end
  if (ROW_W < 11 || COL_W > 10) begin : g_bad_addr
    $error("sdram_burst_read: need ROW_W >= 11 and COL_W <= 10 (A10 is the precharge flag)");
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  rd_state_e          state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [3:0]         cmd_d, cmd_q;
  logic [ROW_W-1:0]   addr_d, addr_q;
  logic [BANK_W-1:0]  ba_d, ba_q;
  logic [1:0]         dqm_d, dqm_q;
  logic               busy_d, busy_q;
  logic               fin_d, fin_q;
  logic               rden_d, rden_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    // cnt_q holds "cycles left in this state minus one"; a state exits when
    // it reaches zero and the next state reloads it on entry.
    unique case (state_q)
      ST_IDLE: begin
        if (ireq && ienb) begin
          state_d = ST_ACT;
          cnt_d   = '0;
        end
      end
      ST_ACT: begin
        if (T_RCD == 1) begin
          state_d = ST_RD;
        end else begin
          state_d = ST_RCD;
          cnt_d   = CNT_W'(T_RCD - 2);
        end
      end
      ST_RCD: begin
        if (cnt_q == '0) state_d = ST_RD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RD: begin
        state_d = ST_CL;
        cnt_d   = CNT_W'(CAS_LAT - 2);
      end
      ST_CL: begin
        if (cnt_q == '0) begin
          state_d = ST_BURST;
          cnt_d   = CNT_W'(BURST_LEN - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) state_d = ST_PRE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_PRE: begin
        if (T_RP == 1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RP;
          cnt_d   = CNT_W'(T_RP - 2);
        end
      end
      ST_RP: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they belong to.
    cmd_d  = CMD_NOP;
    addr_d = '0;
    ba_d   = '0;
    dqm_d  = DQM_ON;
    busy_d = (state_d != ST_IDLE);
    fin_d  = (state_d == ST_DONE);
    rden_d = (state_d == ST_RD) || (state_d == ST_CL) || (state_d == ST_BURST);

    unique case (state_d)
      ST_ACT: begin
        cmd_d  = CMD_ACT;
        addr_d = irow;
        ba_d   = ibank;
      end
      ST_RD: begin
        cmd_d      = CMD_READ;
        addr_d     = ROW_W'(icolumn);
        addr_d[10] = AUTO_PRE;
        ba_d       = ibank;
        dqm_d      = DQM_OFF;
      end
      // DQM stays released for BURST_LEN cycles starting at READ. The CL
      // cycle index after READ is CAS_LAT-1-cnt and the BURST cycle index is
      // CAS_LAT+(BURST_LEN-1-cnt); both are compared against BURST_LEN-1.
      ST_CL: begin
        if (int'(cnt_d) >= CAS_LAT - BURST_LEN) dqm_d = DQM_OFF;
      end
      ST_BURST: begin
        if (int'(cnt_d) >= CAS_LAT) dqm_d = DQM_OFF;
      end
      ST_PRE: begin
        if (!AUTO_PRE) begin
          cmd_d = CMD_PRE;
          ba_d  = ibank;
        end
      end
      default: begin
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      dqm_q   <= DQM_ON;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      rden_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      dqm_q   <= dqm_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      rden_q  <= rden_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Burst capture: the word on DRAM_DQ during BURST cycle k belongs in slot k.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  burst_pos;
  logic [SLOT_W-1:0] slot_idx;

  assign burst_pos = CNT_W'(BURST_LEN - 1) - cnt_q;
  assign slot_idx  = burst_pos[SLOT_W-1:0];

  sdram_burst_capture #(
    .DQ_W      (DQ_W),
    .BURST_LEN (BURST_LEN)
  ) u_capture (
    .iclk   (iclk),
    .ireset (ireset),
    .iwr_en (state_q == ST_BURST),
    .islot  (slot_idx),
    .idq    (DRAM_DQ),
    .odata  (odata)
  );

  // ---------------------------------------------------------------------------
  // Outputs and pin drivers
  // ---------------------------------------------------------------------------
  assign obusy        = busy_q;
  assign ofin         = fin_q;
  assign oread_enable = rden_q;

  assign DRAM_CLK   = ienb ? ~iclk     : 1'bz;
  assign DRAM_CKE   = ienb ? 1'b1      : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q    : {ROW_W{1'bz}};
  assign DRAM_BA    = ienb ? ba_q      : {BANK_W{1'bz}};
  assign DRAM_CS_N  = ienb ? cmd_q[3]  : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2]  : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1]  : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0]  : 1'bz;
  assign DRAM_UDQM  = ienb ? dqm_q[1]  : 1'bz;
  assign DRAM_LDQM  = ienb ? dqm_q[0]  : 1'bz;

endmodule

// File: tb/tb_sdram_burst_read.sv
// -----------------------------------------------------------------------------
// tb_sdram_burst_read
// Two engines share the request inputs: dut_a uses the default parameters,
// dut_b uses BURST_LEN=4, CAS_LAT=3, T_RCD=3. Each has a small SDRAM read
// model returning 0x1111, 0x2222, ... starting CAS_LAT cycles after READ.
// A table of per-cycle expectations covers one transaction; hand-written
// sequences cover back-to-back requests, reset mid-burst and the pin grant.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sdram_burst_read;
  import sdram_pkg::*;

  localparam logic [12:0] ROW  = 13'h1ABC;
  localparam logic [9:0]  COL  = 10'h2F5;
  localparam logic [1:0]  BANK = 2'b10;

`ifdef SDRAM_RD_AUTOPRECHARGE_EN
  localparam logic [3:0]  PRE_CMD = CMD_NOP;
  localparam logic [12:0] RD_A10  = 13'h0400;
  localparam logic [1:0]  PRE_BA  = 2'b00;
`else
  localparam logic [3:0]  PRE_CMD = CMD_PRE;
  localparam logic [12:0] RD_A10  = 13'h0000;
  localparam logic [1:0]  PRE_BA  = BANK;
`endif
  localparam logic [12:0] RD_ADDR = {3'b000, COL} | RD_A10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ireset, ireq, ienb;
  logic [12:0] irow;
  logic [9:0]  icol;
  logic [1:0]  ibank;
  logic [15:0] dq_a, dq_b;

  logic         busy_a, fin_a, rden_a, busy_b, fin_b, rden_b;
  logic [127:0] odata_a;
  logic [63:0]  odata_b;
  wire          clk_a, cke_a, cs_a, ras_a, cas_a, we_a, udqm_a, ldqm_a;
  wire          clk_b, cke_b, cs_b, ras_b, cas_b, we_b, udqm_b, ldqm_b;
  wire [12:0]   addr_a, addr_b;
  wire [1:0]    ba_a, ba_b;

  // A floating CS_N reads 1 and a floating RAS_N reads 0; an idle NOP drives
  // the opposite levels, so these reveal whether the pins are released.
  pullup   (cs_a);
  pulldown (ras_a);

  sdram_burst_read dut_a (
    .iclk(clk), .ireset(ireset), .ireq(ireq), .ienb(ienb),
    .irow(irow), .icolumn(icol), .ibank(ibank),
    .obusy(busy_a), .ofin(fin_a), .odata(odata_a), .oread_enable(rden_a),
    .DRAM_CLK(clk_a), .DRAM_CKE(cke_a), .DRAM_ADDR(addr_a), .DRAM_BA(ba_a),
    .DRAM_CS_N(cs_a), .DRAM_RAS_N(ras_a), .DRAM_CAS_N(cas_a), .DRAM_WE_N(we_a),
    .DRAM_UDQM(udqm_a), .DRAM_LDQM(ldqm_a), .DRAM_DQ(dq_a)
  );

  sdram_burst_read #(.BURST_LEN(4), .CAS_LAT(3), .T_RCD(3)) dut_b (
    .iclk(clk), .ireset(ireset), .ireq(ireq), .ienb(ienb),
    .irow(irow), .icolumn(icol), .ibank(ibank),
    .obusy(busy_b), .ofin(fin_b), .odata(odata_b), .oread_enable(rden_b),
    .DRAM_CLK(clk_b), .DRAM_CKE(cke_b), .DRAM_ADDR(addr_b), .DRAM_BA(ba_b),
    .DRAM_CS_N(cs_b), .DRAM_RAS_N(ras_b), .DRAM_CAS_N(cas_b), .DRAM_WE_N(we_b),
    .DRAM_UDQM(udqm_b), .DRAM_LDQM(ldqm_b), .DRAM_DQ(dq_b)
  );

  // ---------------------------------------------------------------------------
  // SDRAM read models: word k appears during cycle READ+cas+k.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] mem_word(input int age, input int cas, input int bl);
    int k;
    k = age - cas;
    if (k >= 0 && k < bl) return 16'(k + 1) * 16'h1111;
    return 16'hDEAD;
  endfunction

  int age_a = 100;
  int age_b = 100;
  wire rd_seen_a = ({cs_a, ras_a, cas_a, we_a} == CMD_READ);
  wire rd_seen_b = ({cs_b, ras_b, cas_b, we_b} == CMD_READ);

  always @(negedge clk) begin
    age_a <= rd_seen_a ? 0 : ((age_a < 100) ? age_a + 1 : age_a);
    dq_a  <= mem_word(rd_seen_a ? 0 : age_a + 1, 2, 8);
    age_b <= rd_seen_b ? 0 : ((age_b < 100) ? age_b + 1 : age_b);
    dq_b  <= mem_word(rd_seen_b ? 0 : age_b + 1, 3, 4);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]   cmd;
    logic [1:0]   dqm;
    logic         fin, busy, rden;
    logic [12:0]  addr;
    logic [1:0]   ba;
    logic [127:0] odata;
  } obs_t;

  typedef struct {
    int          sel;
    int          cyc;
    logic [3:0]  cmd;
    logic [1:0]  dqm;
    logic        fin, busy, rden;
    logic [12:0] addr;
    logic [1:0]  ba;
  } vec_t;

  obs_t tr [2][48];
  vec_t vecs[$];

  // Runs ncyc cycles starting at cycle 0. ireq is high for cycles
  // 0..req_cyc-1, ireset is high in cycle rst_cyc. Outputs are sampled on the
  // falling edge of each cycle.
  task automatic run_trace(input int ncyc, input int req_cyc, input int rst_cyc);
    for (int c = 0; c < ncyc; c++) begin
      ireq   = (c < req_cyc);
      ireset = (c == rst_cyc);
      @(negedge clk);
      tr[0][c] = '{cmd: {cs_a, ras_a, cas_a, we_a}, dqm: {udqm_a, ldqm_a},
                   fin: fin_a, busy: busy_a, rden: rden_a,
                   addr: addr_a, ba: ba_a, odata: odata_a};
      tr[1][c] = '{cmd: {cs_b, ras_b, cas_b, we_b}, dqm: {udqm_b, ldqm_b},
                   fin: fin_b, busy: busy_b, rden: rden_b,
                   addr: addr_b, ba: ba_b, odata: {64'b0, odata_b}};
      @(posedge clk);
      #1;
    end
    ireq   = 1'b0;
    ireset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int count_fin(input int sel, input int ncyc);
    int n;
    n = 0;
    for (int c = 0; c < ncyc; c++) if (tr[sel][c].fin) n++;
    return n;
  endfunction

  initial begin
    int first_done;
    int second_act;

    ireset = 1'b1;
    ireq   = 1'b0;
    ienb   = 1'b1;
    irow   = ROW;
    icol   = COL;
    ibank  = BANK;

    // Expected per-cycle pin/status values for one transaction from cycle 0.
    //            sel cyc cmd       dqm    fin busy rden addr     ba
    vecs.push_back('{0,  0, CMD_NOP,  DQM_ON,  0, 0, 0, 13'h0,   2'b00});
    vecs.push_back('{0,  1, CMD_ACT,  DQM_ON,  0, 1, 0, ROW,     BANK});
    vecs.push_back('{0,  2, CMD_NOP,  DQM_ON,  0, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{0,  3, CMD_READ, DQM_OFF, 0, 1, 1, RD_ADDR, BANK});
    vecs.push_back('{0,  4, CMD_NOP,  DQM_OFF, 0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{0,  5, CMD_NOP,  DQM_OFF, 0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{0, 10, CMD_NOP,  DQM_OFF, 0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{0, 11, CMD_NOP,  DQM_ON,  0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{0, 12, CMD_NOP,  DQM_ON,  0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{0, 13, PRE_CMD,  DQM_ON,  0, 1, 0, 13'h0,   PRE_BA});
    vecs.push_back('{0, 14, CMD_NOP,  DQM_ON,  0, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{0, 15, CMD_NOP,  DQM_ON,  1, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{0, 16, CMD_NOP,  DQM_ON,  0, 0, 0, 13'h0,   2'b00});
    vecs.push_back('{1,  1, CMD_ACT,  DQM_ON,  0, 1, 0, ROW,     BANK});
    vecs.push_back('{1,  3, CMD_NOP,  DQM_ON,  0, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{1,  4, CMD_READ, DQM_OFF, 0, 1, 1, RD_ADDR, BANK});
    vecs.push_back('{1,  6, CMD_NOP,  DQM_OFF, 0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{1,  7, CMD_NOP,  DQM_OFF, 0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{1,  8, CMD_NOP,  DQM_ON,  0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{1, 10, CMD_NOP,  DQM_ON,  0, 1, 1, 13'h0,   2'b00});
    vecs.push_back('{1, 11, PRE_CMD,  DQM_ON,  0, 1, 0, 13'h0,   PRE_BA});
    vecs.push_back('{1, 12, CMD_NOP,  DQM_ON,  0, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{1, 13, CMD_NOP,  DQM_ON,  1, 1, 0, 13'h0,   2'b00});
    vecs.push_back('{1, 14, CMD_NOP,  DQM_ON,  0, 0, 0, 13'h0,   2'b00});

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    ireset = 1'b0;
    @(negedge clk);
    check("reset_pins_a", {cs_a, ras_a, cas_a, we_a, udqm_a, ldqm_a, addr_a, ba_a},
          {CMD_NOP, DQM_ON, 13'h0, 2'b00});
    check("reset_status_a", {fin_a, busy_a, rden_a}, 3'b000);
    check("reset_odata_a", odata_a, 128'h0);
    check("reset_odata_b", {64'b0, odata_b}, 128'h0);
    @(posedge clk);
    #1;

    // ---- table-driven single transaction ----
    run_trace(20, 1, -1);
    foreach (vecs[i]) begin
      obs_t o;
      o = tr[vecs[i].sel][vecs[i].cyc];
      check($sformatf("vec_%s_c%0d", vecs[i].sel == 0 ? "a" : "b", vecs[i].cyc),
            {o.cmd, o.dqm, o.fin, o.busy, o.rden, o.addr, o.ba},
            {vecs[i].cmd, vecs[i].dqm, vecs[i].fin, vecs[i].busy, vecs[i].rden,
             vecs[i].addr, vecs[i].ba});
    end
    check("burst_data_a", odata_a, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    check("burst_data_b", {64'b0, odata_b}, {64'b0, 64'h1111_2222_3333_4444});
    check("fin_count_a", count_fin(0, 20), 1);
    check("fin_count_b", count_fin(1, 20), 1);

    // ---- ireq held high: one ofin per transaction, next ACT 2 after DONE ----
    run_trace(36, 36, -1);
    first_done = -1;
    second_act = -1;
    for (int c = 0; c < 36; c++) begin
      if (first_done < 0 && tr[0][c].fin) first_done = c;
      else if (first_done >= 0 && second_act < 0 && tr[0][c].cmd == CMD_ACT) second_act = c;
    end
    check("b2b_done_cycle", first_done, 15);
    check("b2b_second_act", second_act, 17);
    check("b2b_fin_count", count_fin(0, 36), 2);
    idle_cycles(20);

    // ---- reset during BURST word 3 (cycle 8 for dut_a) ----
    run_trace(12, 1, 8);
    check("hold_prev_data", tr[0][4].odata, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    check("abort_in_burst", {tr[0][8].busy, tr[0][8].rden}, 2'b11);
    check("abort_pins", {tr[0][9].cmd, tr[0][9].dqm}, {CMD_NOP, DQM_ON});
    check("abort_status", {tr[0][9].fin, tr[0][9].busy, tr[0][9].rden}, 3'b000);
    check("abort_odata_a", tr[0][9].odata, 128'h0);
    check("abort_odata_b", tr[1][9].odata, 128'h0);
    run_trace(16, 0, -1);
    check("abort_no_fin_a", count_fin(0, 12) + count_fin(0, 16), 0);
    check("abort_no_fin_b", count_fin(1, 16), 0);
    run_trace(20, 1, -1);
    check("after_abort_fin", {tr[0][14].fin, tr[0][15].fin, tr[0][16].fin}, 3'b010);
    check("after_abort_data", odata_a, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

    // ---- grant low with request high: stay idle, pins released ----
    ienb = 1'b0;
    run_trace(6, 6, -1);
    check("noenb_cs_z", tr[0][3].cmd[3], 1'b1);
    check("noenb_ras_z", tr[0][3].cmd[2], 1'b0);
    check("noenb_idle", {tr[0][5].busy, tr[1][5].busy}, 2'b00);
    ienb = 1'b1;
    ireq = 1'b1;
    @(negedge clk);
    check("enb_cycle0", {cs_a, ras_a, cas_a, we_a, busy_a}, {CMD_NOP, 1'b0});
    @(posedge clk);
    #1;
    ireq = 1'b0;
    @(negedge clk);
    check("enb_act", {cs_a, ras_a, cas_a, we_a, addr_a, ba_a, busy_a}, {CMD_ACT, ROW, BANK, 1'b1});
    idle_cycles(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
